legv8_multicycle_ctrl: RTL and testbench

Multicycle control FSM for the LEGv8 datapath. It decodes the 11-bit opcode field (IR[31:21]) and sequences instruction memory, register file, SignExtender, ALU and data memory over 3–5+ cycles per instruction. It drives the SignExtender select (SignOp) and ALU control, and waits on a shared-memory ready handshake. It also counts retired instructions for the lab performance bench.

---
 rtl/legv8_multicycle_ctrl.sv | 162 ++++++++++++++++
 tb/tb_legv8_multicycle_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/legv8_multicycle_ctrl.sv
// legv8_multicycle_ctrl: multicycle LEGv8 control FSM sequencing fetch, decode, execute, memory and write-back.
module legv8_multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             Clk,
    input  logic             Reset_L,
    input  logic [10:0]      Opcode,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             PCWrite,
    output logic             PCSrc,
    output logic             IRWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IorD,
    output logic             Reg2Loc,
    output logic             ALUSrc,
    output logic [3:0]       ALUCtrl,
    output logic [2:0]       SignOp,
    output logic             MemToReg,
    output logic             RegWrite,
    output logic             Illegal,
    output logic [2:0]       State,
    output logic [CNT_W-1:0] InstRetired
);
    typedef enum logic [2:0] {RST = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3, MEM = 3'd4, WB = 3'd5} state_t;
    typedef enum logic [3:0] {
        OP_NONE, OP_B, OP_CBZ, OP_LDUR, OP_STUR, OP_ADDI, OP_SUBI,
        OP_MOVZ, OP_LSL, OP_LSR, OP_ADD, OP_SUB, OP_AND, OP_ORR
    } op_t;

    state_t            state, nxt;
    op_t               op_q, dec_op;
    logic              retire, branch, mem_op;
    logic [CNT_W-1:0]  cnt;

    // Prefix decode; casez arms are tried top to bottom so the first match wins.
    function automatic op_t decode(input logic [10:0] opc);
        casez (opc)
            11'b000101?????: decode = OP_B;
            11'b10110100???: decode = OP_CBZ;
            11'b11111000010: decode = OP_LDUR;
            11'b11111000000: decode = OP_STUR;
            11'b1001000100?: decode = OP_ADDI;
            11'b1101000100?: decode = OP_SUBI;
            11'b110100101??: decode = OP_MOVZ;
            11'b11010011011: decode = OP_LSL;
            11'b11010011010: decode = OP_LSR;
            11'b10001011000: decode = OP_ADD;
            11'b11001011000: decode = OP_SUB;
            11'b10001010000: decode = OP_AND;
            11'b10101010000: decode = OP_ORR;
            default:         decode = OP_NONE;
        endcase
    endfunction

    function automatic logic [2:0] signop_of(input op_t op);
        case (op)
            OP_B:              signop_of = 3'b010;
            OP_CBZ:            signop_of = 3'b011;
            OP_LDUR, OP_STUR:  signop_of = 3'b001;
            OP_MOVZ:           signop_of = 3'b100;
            OP_LSL, OP_LSR:    signop_of = 3'b101;
            default:           signop_of = 3'b000;
        endcase
    endfunction

    function automatic logic [3:0] alu_of(input op_t op);
        case (op)
            OP_ADD, OP_ADDI, OP_LDUR, OP_STUR: alu_of = 4'b0010;
            OP_SUB, OP_SUBI:                   alu_of = 4'b0110;
            OP_ORR:                            alu_of = 4'b0001;
            OP_MOVZ, OP_CBZ:                   alu_of = 4'b0111;
            OP_LSL:                            alu_of = 4'b0011;
            OP_LSR:                            alu_of = 4'b0100;
            default:                           alu_of = 4'b0000;
        endcase
    endfunction

    function automatic logic alusrc_of(input op_t op);
        alusrc_of = op inside {OP_ADDI, OP_SUBI, OP_LSL, OP_LSR, OP_MOVZ, OP_LDUR, OP_STUR};
    endfunction

    assign dec_op      = decode(Opcode);
    assign branch      = op_q inside {OP_B, OP_CBZ};
    assign mem_op      = op_q inside {OP_LDUR, OP_STUR};
    assign State       = state;
    assign InstRetired = cnt;

    always_ff @(posedge Clk) begin
        if (!Reset_L) begin
            state <= RST;
            op_q  <= OP_NONE;
            cnt   <= '0;
        end else begin
            state <= nxt;
            if (state == DECODE) op_q <= dec_op;
            if (retire) cnt <= cnt + CNT_W'(1);
        end
    end

    always_comb begin
        nxt      = state;
        retire   = 1'b0;
        PCWrite  = 1'b0;
        PCSrc    = 1'b0;
        IRWrite  = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IorD     = 1'b0;
        Reg2Loc  = 1'b0;
        ALUSrc   = 1'b0;
        ALUCtrl  = 4'b0000;
        SignOp   = 3'b000;
        MemToReg = 1'b0;
        RegWrite = 1'b0;
        Illegal  = 1'b0;
        case (state)
            RST: nxt = FETCH;
            FETCH: begin
                MemRead = 1'b1;
                IRWrite = MemReady;
                PCWrite = MemReady;
                nxt     = MemReady ? DECODE : FETCH;
            end
            // SignOp follows the raw opcode so the branch target is ready by EXEC.
            DECODE: begin
                SignOp  = signop_of(dec_op);
                Illegal = dec_op == OP_NONE;
                nxt     = Illegal ? FETCH : EXEC;
            end
            EXEC: begin
                SignOp  = signop_of(op_q);
                ALUCtrl = alu_of(op_q);
                ALUSrc  = alusrc_of(op_q);
                Reg2Loc = op_q inside {OP_STUR, OP_CBZ};
                PCSrc   = branch;
                PCWrite = op_q == OP_B || (op_q == OP_CBZ && Zero);
                retire  = branch;
                nxt     = branch ? FETCH : mem_op ? MEM : WB;
            end
            MEM: begin
                IorD     = 1'b1;
                SignOp   = signop_of(op_q);
                ALUCtrl  = alu_of(op_q);
                ALUSrc   = alusrc_of(op_q);
                Reg2Loc  = op_q == OP_STUR;
                MemRead  = op_q == OP_LDUR;
                MemWrite = op_q == OP_STUR;
                retire   = MemReady && op_q == OP_STUR;
                nxt      = !MemReady ? MEM : op_q == OP_STUR ? FETCH : WB;
            end
            WB: begin
                RegWrite = 1'b1;
                MemToReg = op_q == OP_LDUR;
                retire   = 1'b1;
                nxt      = FETCH;
            end
            default: nxt = RST;
        endcase
    end
endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// tb_legv8_multicycle_ctrl: directed and random instruction streams checked against a per-instruction table model.
module tb_legv8_multicycle_ctrl;
    localparam int CW = 4;
    localparam int C_ILL = 0, C_B = 1, C_CBZ = 2, C_LDUR = 3, C_STUR = 4, C_ADDI = 5, C_SUBI = 6,
                   C_MOVZ = 7, C_LSL = 8, C_LSR = 9, C_ADD = 10, C_SUB = 11, C_AND = 12, C_ORR = 13;

    localparam logic [2:0]  SOP  [14] = '{3'b000, 3'b010, 3'b011, 3'b001, 3'b001, 3'b000, 3'b000,
                                          3'b100, 3'b101, 3'b101, 3'b000, 3'b000, 3'b000, 3'b000};
    localparam logic [3:0]  ALU  [14] = '{4'b0000, 4'b0000, 4'b0111, 4'b0010, 4'b0010, 4'b0010, 4'b0110,
                                          4'b0111, 4'b0011, 4'b0100, 4'b0010, 4'b0110, 4'b0000, 4'b0001};
    localparam bit          ASRC [14] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    localparam logic [10:0] BASE [14] = '{11'b00000000000, 11'b00010100000, 11'b10110100000, 11'b11111000010,
                                          11'b11111000000, 11'b10010001000, 11'b11010001000, 11'b11010010100,
                                          11'b11010011011, 11'b11010011010, 11'b10001011000, 11'b11001011000,
                                          11'b10001010000, 11'b10101010000};
    localparam logic [10:0] DC   [14] = '{11'h7ff, 11'h01f, 11'h007, 11'h000, 11'h000, 11'h001, 11'h001,
                                          11'h003, 11'h000, 11'h000, 11'h000, 11'h000, 11'h000, 11'h000};

    typedef struct packed {
        logic pcw, pcs, irw, mrd, mwr, iord, r2l, asrc;
        logic [3:0] alu;
        logic [2:0] sop;
        logic m2r, rw, ill;
    } ctl_t;

    logic          Clk = 0, Reset_L = 0, Zero = 0, MemReady = 0;
    logic [10:0]   Opcode = '0;
    logic          PCWrite, PCSrc, IRWrite, MemRead, MemWrite, IorD, Reg2Loc, ALUSrc, MemToReg, RegWrite, Illegal;
    logic [3:0]    ALUCtrl;
    logic [2:0]    SignOp, State;
    logic [CW-1:0] InstRetired;

    int          n_vec = 0, n_err = 0, exp_cnt = 0, cur_cls = 0;
    logic [10:0] cur_opc = '0;
    logic        cur_z = 0;

    legv8_multicycle_ctrl #(.CNT_W(CW)) dut (
        .Clk(Clk), .Reset_L(Reset_L), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCSrc(PCSrc), .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .IorD(IorD), .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc), .ALUCtrl(ALUCtrl), .SignOp(SignOp),
        .MemToReg(MemToReg), .RegWrite(RegWrite), .Illegal(Illegal), .State(State), .InstRetired(InstRetired)
    );

    always #5 Clk = ~Clk;

    function automatic int cls_of(input logic [10:0] o);
        if (o ==? 11'b000101?????) return C_B;
        if (o ==? 11'b10110100???) return C_CBZ;
        if (o ==  11'b11111000010) return C_LDUR;
        if (o ==  11'b11111000000) return C_STUR;
        if (o ==? 11'b1001000100?) return C_ADDI;
        if (o ==? 11'b1101000100?) return C_SUBI;
        if (o ==? 11'b110100101??) return C_MOVZ;
        if (o ==  11'b11010011011) return C_LSL;
        if (o ==  11'b11010011010) return C_LSR;
        if (o ==  11'b10001011000) return C_ADD;
        if (o ==  11'b11001011000) return C_SUB;
        if (o ==  11'b10001010000) return C_AND;
        if (o ==  11'b10101010000) return C_ORR;
        return C_ILL;
    endfunction

    // Expected controls for one cycle of the current instruction; mask clears fields left open per phase.
    function automatic void model(input int st, input logic mr, output ctl_t e, output ctl_t m);
        bit br  = cur_cls == C_B || cur_cls == C_CBZ;
        bit ld  = cur_cls == C_LDUR;
        bit stu = cur_cls == C_STUR;
        e = '0;
        m = '1;
        case (st)
            1: begin e.mrd = 1; e.irw = mr; e.pcw = mr; end
            2: begin
                e.sop = SOP[cur_cls]; e.ill = cur_cls == C_ILL;
                m.pcs = 0; m.iord = 0; m.r2l = 0; m.asrc = 0; m.alu = '0; m.m2r = 0;
            end
            3: begin
                e.sop = SOP[cur_cls]; e.alu = ALU[cur_cls]; e.asrc = ASRC[cur_cls];
                e.r2l = stu || cur_cls == C_CBZ; e.pcs = br;
                e.pcw = cur_cls == C_B || (cur_cls == C_CBZ && cur_z);
                if (!br) m.pcs = 0;
                if (cur_cls == C_B) begin m.alu = '0; m.asrc = 0; end
                if (cur_cls == C_CBZ) m.asrc = 0;
                if (cur_cls >= C_ADD) m.sop = '0;
            end
            4: begin
                e.iord = 1; e.sop = 3'b001; e.alu = 4'b0010; e.asrc = 1; e.r2l = stu;
                e.mrd = ld; e.mwr = stu; m.pcs = 0;
            end
            5: begin
                e.rw = 1; e.m2r = ld;
                m.pcs = 0; m.iord = 0; m.r2l = 0; m.asrc = 0; m.alu = '0; m.sop = '0;
            end
            default: ;
        endcase
    endfunction

    task automatic cyc(input int st, input logic mr, input bit ret);
        ctl_t e, m, a;
        MemReady = mr;
        Opcode   = (st == 2) ? cur_opc : 11'($urandom);
        Zero     = (st == 3) ? cur_z : 1'($urandom);
        @(negedge Clk);
        model(st, mr, e, m);
        a = {PCWrite, PCSrc, IRWrite, MemRead, MemWrite, IorD, Reg2Loc, ALUSrc, ALUCtrl, SignOp, MemToReg, RegWrite, Illegal};
        n_vec++;
        assert ((a & m) === (e & m)) else begin
            n_err++;
            $error("FAIL ctl st=%0d opc=%b got=%h exp=%h mask=%h", st, cur_opc, a, e, m);
        end
        assert (State === 3'(st)) else begin
            n_err++;
            $error("FAIL state opc=%b got=%0d exp=%0d", cur_opc, State, st);
        end
        assert (InstRetired === CW'(exp_cnt)) else begin
            n_err++;
            $error("FAIL retired st=%0d got=%0d exp=%0d", st, InstRetired, exp_cnt);
        end
        @(posedge Clk);
        #1;
        if (ret) exp_cnt = (exp_cnt + 1) % (1 << CW);
    endtask

    task automatic run(input logic [10:0] opc, input logic z, input int fw, input int mw);
        cur_opc = opc;
        cur_cls = cls_of(opc);
        cur_z   = z;
        repeat (fw) cyc(1, 0, 0);
        cyc(1, 1, 0);
        cyc(2, 1'($urandom), 0);
        if (cur_cls == C_ILL) return;
        if (cur_cls == C_B || cur_cls == C_CBZ) begin
            cyc(3, 1'($urandom), 1);
            return;
        end
        cyc(3, 1'($urandom), 0);
        if (cur_cls == C_LDUR || cur_cls == C_STUR) begin
            repeat (mw) cyc(4, 0, 0);
            cyc(4, 1, cur_cls == C_STUR);
            if (cur_cls == C_STUR) return;
        end
        cyc(5, 1'($urandom), 1);
    endtask

    initial begin
        int k;
        logic [10:0] o;
        Reset_L = 0;
        @(posedge Clk);
        #1;
        cyc(0, 0, 0);
        Reset_L = 1;
        cyc(0, 1, 0);
        run(11'b10010001000, 0, 0, 0);
        run(11'b11111000010, 0, 0, 3);
        run(11'b10110100101, 1, 0, 0);
        run(11'b10110100101, 0, 0, 0);
        run(11'b00000000000, 0, 0, 0);
        run(11'b00010111011, 0, 1, 0);
        run(11'b11111000000, 0, 2, 2);
        // Reset lands while a store is stalled in MEM.
        cur_opc = 11'b11111000000;
        cur_cls = C_STUR;
        cyc(1, 1, 0);
        cyc(2, 1, 0);
        cyc(3, 1, 0);
        cyc(4, 0, 0);
        Reset_L = 0;
        cyc(4, 0, 0);
        exp_cnt = 0;
        Reset_L = 1;
        cyc(0, 0, 0);
        repeat (17) run(11'b11010010100, 0, 0, 0);
        n_vec++;
        assert (InstRetired === 4'd1) else begin
            n_err++;
            $error("FAIL wrap got=%0d exp=1", InstRetired);
        end
        repeat (150) begin
            k = $urandom_range(0, 15);
            o = (k < 14) ? (BASE[k] | (11'($urandom) & DC[k])) : 11'($urandom);
            run(o, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
